// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the CPU clock controller: state encoding,
// default setting width and the half-period clamp.
package clk_ctrl_pkg;

    localparam int CLK_CTRL_DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_HALTED   = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2,
        ST_DRAIN    = 2'd3
    } clk_state_e;

    // A half-period of zero would never toggle, so it is promoted to one.
    function automatic logic [31:0] clamp_half(input logic [31:0] value);
        return (value == 32'd0) ? 32'd1 : value;
    endfunction

endpackage

// File: rtl/cpu_clock_controller.sv
// Run/halt/single-step controller producing a glitch-free divided CPU clock
// with a valid/ready reprogrammable half-period.
module cpu_clock_controller
    import clk_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH     = CLK_CTRL_DIV_WIDTH,
    parameter int DEFAULT_HALF  = 2,
    parameter bit START_RUNNING = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    input  logic [DIV_WIDTH-1:0] cfg_half,
    output logic                 cfg_ready,
    input  logic                 run,
    input  logic                 halt_req,
    input  logic                 step_req,
    output logic                 out_clk,
    output logic                 rise_pulse,
    output logic                 halted,
    output logic [15:0]          period_count
);

    localparam logic [DIV_WIDTH-1:0] ONE        = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] RESET_HALF = DIV_WIDTH'(clamp_half(32'(DEFAULT_HALF)));
    localparam clk_state_e           RESET_STATE = START_RUNNING ? ST_RUNNING : ST_HALTED;

    clk_state_e           state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] half_q, half_d;
    logic [DIV_WIDTH-1:0] pend_half_q, pend_half_d;
    logic                 pend_valid_q, pend_valid_d;
    logic                 out_clk_q, out_clk_d;
    logic                 rise_q, rise_d;
    logic [15:0]          period_q, period_d;
    logic                 phase_done;
    logic                 stop_req;

    // NOTE: every signal gets a default at the top so no path through the
    // case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        half_d       = half_q;
        pend_half_d  = pend_half_q;
        pend_valid_d = pend_valid_q;
        out_clk_d    = out_clk_q;
        rise_d       = 1'b0;
        period_d     = period_q;
        phase_done   = (cnt_q == half_q - ONE);
        stop_req     = halt_req || !run;

        if (cfg_valid && !pend_valid_q) begin
            pend_half_d  = DIV_WIDTH'(clamp_half(32'(cfg_half)));
            pend_valid_d = 1'b1;
        end

        case (state_q)
            ST_HALTED: begin
                cnt_d     = '0;
                out_clk_d = 1'b0;
                if (pend_valid_q) begin
                    half_d       = pend_half_q;
                    pend_valid_d = 1'b0;
                end
                if (run) begin
                    state_d = ST_RUNNING;
                end else if (step_req) begin
                    state_d = ST_STEPPING;
                end
            end
            default: begin
                // A stop in the low phase is immediate; in the high phase the
                // high level is first allowed to run out through DRAIN.
                if ((state_q == ST_RUNNING && stop_req && !out_clk_q) ||
                    (state_q == ST_DRAIN && !out_clk_q)) begin
                    state_d = ST_HALTED;
                    cnt_d   = '0;
                end else begin
                    if (state_q == ST_RUNNING && stop_req) begin
                        state_d = ST_DRAIN;
                    end
                    if (phase_done) begin
                        cnt_d     = '0;
                        out_clk_d = !out_clk_q;
                        if (!out_clk_q) begin
                            rise_d   = 1'b1;
                            period_d = period_q + 16'd1;
                            // New settings take effect at a rising toggle so
                            // the high and low halves always match.
                            if (pend_valid_q) begin
                                half_d       = pend_half_q;
                                pend_valid_d = 1'b0;
                            end
                        end else if (state_q == ST_STEPPING) begin
                            state_d = ST_HALTED;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            cnt_q        <= '0;
            half_q       <= RESET_HALF;
            pend_half_q  <= RESET_HALF;
            pend_valid_q <= 1'b0;
            out_clk_q    <= 1'b0;
            rise_q       <= 1'b0;
            period_q     <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            half_q       <= half_d;
            pend_half_q  <= pend_half_d;
            pend_valid_q <= pend_valid_d;
            out_clk_q    <= out_clk_d;
            rise_q       <= rise_d;
            period_q     <= period_d;
        end
    end

    assign cfg_ready    = !pend_valid_q;
    assign out_clk      = out_clk_q;
    assign rise_pulse   = rise_q;
    assign halted       = (state_q == ST_HALTED);
    assign period_count = period_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Self-checking bench for cpu_clock_controller: directed scenarios with literal
// expectations plus randomized traffic compared against a phase-level model.
module tb_cpu_clock_controller;

    logic        clk;
    logic        reset;
    logic        cfg_valid;
    logic [7:0]  cfg_half;
    logic        cfg_ready;
    logic        run;
    logic        halt_req;
    logic        step_req;
    logic        out_clk;
    logic        rise_pulse;
    logic        halted;
    logic [15:0] period_count;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_clock_controller #(
        .DIV_WIDTH    (8),
        .DEFAULT_HALF (2),
        .START_RUNNING(1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_half    (cfg_half),
        .cfg_ready   (cfg_ready),
        .run         (run),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .out_clk     (out_clk),
        .rise_pulse  (rise_pulse),
        .halted      (halted),
        .period_count(period_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: the clock is a sequence of phases, each lasting
    // 'half' cycles, tracked by the cycles left in the current phase.
    typedef enum {M_STOP, M_FREE, M_DRAIN, M_ONE} mode_e;

    mode_e       m_mode;
    logic        m_level;
    logic        m_rise;
    logic        m_fell;
    logic [15:0] m_count;
    int          m_left;
    int          m_half;
    int          m_pend;
    bit          m_pend_v;
    bit          m_take;
    int          m_took;

    task automatic advance();
        m_fell = 1'b0;
        m_left = m_left - 1;
        if (m_left == 0) begin
            if (!m_level) begin
                m_level = 1'b1;
                m_rise  = 1'b1;
                m_count = m_count + 16'd1;
                if (m_pend_v) begin
                    m_half   = m_pend;
                    m_pend_v = 1'b0;
                end
            end else begin
                m_level = 1'b0;
                m_fell  = 1'b1;
            end
            m_left = m_half;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode   = M_FREE;
            m_level  = 1'b0;
            m_rise   = 1'b0;
            m_count  = 16'd0;
            m_half   = 2;
            m_left   = 2;
            m_pend_v = 1'b0;
            m_pend   = 2;
        end else begin
            m_take = cfg_valid && !m_pend_v;
            m_took = (cfg_half == 8'd0) ? 1 : int'(cfg_half);
            m_rise = 1'b0;
            case (m_mode)
                M_STOP: begin
                    if (m_pend_v) begin
                        m_half   = m_pend;
                        m_pend_v = 1'b0;
                    end
                    if (run) begin
                        m_mode = M_FREE;
                        m_left = m_half;
                    end else if (step_req) begin
                        m_mode = M_ONE;
                        m_left = m_half;
                    end
                end
                M_FREE: begin
                    if ((halt_req || !run) && !m_level) begin
                        m_mode = M_STOP;
                    end else begin
                        if (halt_req || !run) m_mode = M_DRAIN;
                        advance();
                    end
                end
                M_DRAIN: begin
                    if (!m_level) m_mode = M_STOP;
                    else advance();
                end
                M_ONE: begin
                    advance();
                    if (m_fell) m_mode = M_STOP;
                end
            endcase
            if (m_take) begin
                m_pend   = m_took;
                m_pend_v = 1'b1;
            end
        end
    end

    // Every cycle out of reset, all outputs are compared with the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("cmp_out_clk", 32'(out_clk), 32'(m_level));
            check("cmp_rise_pulse", 32'(rise_pulse), 32'(m_rise));
            check("cmp_halted", 32'(halted), 32'(m_mode == M_STOP));
            check("cmp_cfg_ready", 32'(cfg_ready), 32'(!m_pend_v));
            check("cmp_period_count", 32'(period_count), 32'(m_count));
        end
    end

    task automatic step_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return out_clk;
            1:       return halted;
            2:       return cfg_ready;
            default: return rise_pulse;
        endcase
    endfunction

    task automatic wait_for(input string name, input int sel, input logic val, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sig(sel) == val) begin
                seen = 1'b1;
                break;
            end
            step_cycles(1);
        end
        check({"wait_", name}, 32'(seen), 32'd1);
    endtask

    bit step_out  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bit step_halt [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bit drain_out [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit drain_halt[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [15:0] c0;
        run       = 1'b1;
        halt_req  = 1'b0;
        step_req  = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = 8'd0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_clk", 32'(out_clk), 32'd0);
        check("reset_rise", 32'(rise_pulse), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        check("reset_period", 32'(period_count), 32'd0);
        reset = 1'b0;

        // Default divide-by-4: 0,0,1,1 with a rise pulse on each first high cycle.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("default_out_%0d", i), 32'(out_clk), 32'((i % 4) >= 2));
            check($sformatf("default_rise_%0d", i), 32'(rise_pulse), 32'((i % 4) == 2));
        end
        check("default_period_20", 32'(period_count), 32'd5);
        @(posedge clk);
        #1;

        // Halt in the low phase, then a single step.
        wait_for("high_a", 0, 1'b1, 10);
        wait_for("low_a", 0, 1'b0, 10);
        halt_req = 1'b1;
        run      = 1'b0;
        step_cycles(1);
        halt_req = 1'b0;
        check("halt_low_halted", 32'(halted), 32'd1);
        check("halt_low_out", 32'(out_clk), 32'd0);
        c0 = period_count;
        step_cycles(3);
        check("halt_low_stays", 32'(halted), 32'd1);
        step_req = 1'b1;
        step_cycles(1);
        step_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("step_out_%0d", k), 32'(out_clk), 32'(step_out[k]));
            check($sformatf("step_halted_%0d", k), 32'(halted), 32'(step_halt[k]));
            step_cycles(1);
        end
        check("step_period", 32'(period_count), 32'(c0 + 16'd1));

        // Halt requested in the first high cycle with half=3.
        cfg_valid = 1'b1;
        cfg_half  = 8'd3;
        step_cycles(1);
        cfg_valid = 1'b0;
        check("cfg3_ready_low", 32'(cfg_ready), 32'd0);
        step_cycles(1);
        check("cfg3_applied_halted", 32'(cfg_ready), 32'd1);
        run = 1'b1;
        step_cycles(1);
        wait_for("high_b", 0, 1'b1, 20);
        halt_req = 1'b1;
        run      = 1'b0;
        step_cycles(1);
        halt_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_out_%0d", k), 32'(out_clk), 32'(drain_out[k]));
            check($sformatf("drain_halted_%0d", k), 32'(halted), 32'(drain_halt[k]));
            step_cycles(1);
        end

        // Reconfigure from half=2 to half=5 during a low phase.
        cfg_valid = 1'b1;
        cfg_half  = 8'd2;
        step_cycles(1);
        cfg_valid = 1'b0;
        step_cycles(1);
        run = 1'b1;
        step_cycles(1);
        wait_for("high_c", 0, 1'b1, 20);
        wait_for("low_c", 0, 1'b0, 20);
        cfg_valid = 1'b1;
        cfg_half  = 8'd5;
        step_cycles(1);
        cfg_valid = 1'b0;
        check("cfg5_ready_low", 32'(cfg_ready), 32'd0);
        check("cfg5_still_low", 32'(out_clk), 32'd0);
        step_cycles(1);
        check("cfg5_ready_back", 32'(cfg_ready), 32'd1);
        check("cfg5_rise", 32'(rise_pulse), 32'd1);
        for (int k = 0; k <= 10; k++) begin
            check($sformatf("cfg5_out_%0d", k), 32'(out_clk), 32'(k < 5 || k == 10));
            step_cycles(1);
        end

        // Zero half-period is clamped to one: period of two cycles.
        cfg_valid = 1'b1;
        cfg_half  = 8'd0;
        step_cycles(1);
        cfg_valid = 1'b0;
        wait_for("clamp_apply", 2, 1'b1, 30);
        check("clamp_first_high", 32'(out_clk), 32'd1);
        for (int k = 0; k < 6; k++) begin
            step_cycles(1);
            check($sformatf("clamp_out_%0d", k), 32'(out_clk), 32'((k % 2) == 1));
        end

        // run and step_req together in HALTED: run wins and keeps going.
        halt_req = 1'b1;
        run      = 1'b0;
        step_cycles(1);
        halt_req = 1'b0;
        wait_for("halt_d", 1, 1'b1, 10);
        run      = 1'b1;
        step_req = 1'b1;
        step_cycles(1);
        step_req = 1'b0;
        check("simul_running", 32'(halted), 32'd0);
        c0 = period_count;
        step_cycles(10);
        check("simul_periods", 32'(period_count - c0), 32'd5);
        check("simul_still_running", 32'(halted), 32'd0);

        // Reset in the middle of a high phase with a setting pending.
        cfg_valid = 1'b1;
        cfg_half  = 8'd4;
        step_cycles(1);
        cfg_valid = 1'b0;
        wait_for("cfg4_apply", 2, 1'b1, 10);
        cfg_valid = 1'b1;
        cfg_half  = 8'd7;
        step_cycles(1);
        cfg_valid = 1'b0;
        check("midhigh_pending", 32'(cfg_ready), 32'd0);
        check("midhigh_out", 32'(out_clk), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_out", 32'(out_clk), 32'd0);
        check("async_reset_period", 32'(period_count), 32'd0);
        check("async_reset_ready", 32'(cfg_ready), 32'd1);
        step_cycles(2);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_out_%0d", i), 32'(out_clk), 32'((i % 4) >= 2));
        end
        @(posedge clk);
        #1;

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            run       = ($urandom_range(0, 9) != 0);
            halt_req  = ($urandom_range(0, 15) == 0);
            step_req  = ($urandom_range(0, 7) == 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_half  = 8'($urandom_range(0, 5));
            step_cycles(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_clock_controller.md
# cpu_clock_controller

Run/halt/single-step controller for the processor's divided clock. The block generates `out_clk`, a glitch-free square wave at a programmable rate, from the board clock. It accepts a new half-period setting through a valid/ready handshake and can halt the processor clock on a clean boundary or issue exactly one clock period. It sits between the board clock and the CPU/debug logic, and replaces the fixed divide-by-4.

## Interface
- `DIV_WIDTH`, default 8: width of the half-period setting.
- `DEFAULT_HALF`, default 2: reset half-period in `clk` cycles; 2 gives divide-by-4.
- `START_RUNNING`, default 1: 1 = RUNNING after reset, 0 = HALTED.

Ports (name, direction, width, meaning):
- `clk` input 1: board clock.
- `reset` input 1: asynchronous, active-high.
- `cfg_valid` input 1: new half-period offered.
- `cfg_half` input DIV_WIDTH: requested half-period; 0 is treated as 1.
- `cfg_ready` output 1: controller can accept a setting.
- `run` input 1: level; start or continue free-running.
- `halt_req` input 1: pulse or level; stop at the next clean boundary.
- `step_req` input 1: pulse; issue one `out_clk` period from HALTED.
- `out_clk` output 1: divided clock.
- `rise_pulse` output 1: 1-cycle pulse in the `clk` cycle in which `out_clk` becomes 1.
- `halted` output 1: state is HALTED.
- `period_count` output 16: count of `out_clk` rising edges, wraps.

## Operation
- **States:** HALTED, RUNNING, STEPPING, DRAIN.
- **Counting and toggling:**
  - `cnt` counts 0..`half`-1 in every state except HALTED.
  - At `cnt`==`half`-1: `out_clk` toggles and `cnt` returns to 0.
- **Phase order:** each period is a low phase followed by a high phase.
- **HALTED:**
  - `out_clk`=0, `cnt` held at 0.
  - `run`=1 → RUNNING.
  - Else `step_req`=1 → STEPPING.
- **RUNNING:**
  - `halt_req` with `out_clk`=0 → HALTED next cycle.
  - `halt_req` with `out_clk`=1 → DRAIN.
  - `run`=0 with no `halt_req` is treated as `halt_req`.
- **DRAIN:** continue to the falling toggle, then → HALTED. Other requests are ignored.
- **STEPPING:** run one low phase and one high phase; at the falling toggle → HALTED. `run`, `halt_req` and `step_req` are ignored.
- **Simultaneous requests:**
  - In HALTED: `run` beats `step_req`.
  - In RUNNING: `halt_req` beats `run`.
- **Configuration handshake:**
  - `cfg_ready` = !`pend_valid`.
  - A transfer happens on `cfg_valid`&&`cfg_ready`; it loads `pend_half` and sets `pend_valid`.
- **Applying a pending setting:**
  - In HALTED: `half` <= `pend_half` on the next cycle.
  - Otherwise: `half` <= `pend_half` on the rising toggle, so the new value governs the whole high phase and all later phases.
  - `pend_valid` clears in the same cycle.
- **Period counter:** `period_count` increments on every rising toggle, modulo 2^16.

## Timing
- **Reset values:**
  - `out_clk`=0, `rise_pulse`=0, `cnt`=0, `period_count`=0.
  - `half`=`DEFAULT_HALF`, `pend_valid`=0, `cfg_ready`=1.
  - state = RUNNING if `START_RUNNING`, else HALTED; `halted` matches the state.
- **Reset mid-phase:** `out_clk` goes to 0 immediately. A shortened high pulse is accepted only on reset.
- **Period length:** 2·`half` `clk` cycles; duty cycle exactly 50%.
- **Start from HALTED:** `run` sampled at edge N → RUNNING at N+1. First rise at edge N+1+`half`.
- **Single step:** exactly `half` cycles low, then `half` high. `halted`=1 on the cycle after the falling toggle.
- **Halt latency:**
  - 1 cycle when `out_clk`=0.
  - Otherwise the remaining high-phase cycles, then 1 cycle.
- **Output registration:** `rise_pulse` is registered and coincident with `out_clk` becoming 1.
- **Setting accepted on a rising-toggle edge:** not applied at that edge; it applies at the next rising toggle.
- **Counter wrap:** `period_count` goes 0xFFFF → 0x0000 with no flag.

## Structure
- **Shared package `clk_ctrl_pkg`:**
  - state enum encoding.
  - `DIV_WIDTH` default.
  - the zero-to-one clamp helper function.
- **Sub-modules:** none; a single flat module. `cnt`/`half` compare and the state register live together.

## Test plan
- **Default run:** reset released, `START_RUNNING`=1, `half`=2 → `out_clk` pattern 0,0,1,1 repeating. `rise_pulse` every 4 cycles. `period_count`=5 after 20 cycles.
- **Halt in low phase:** `halt_req` pulsed with `out_clk`=0 → `halted`=1 next cycle and `out_clk` stays 0. Then `step_req` → exactly 2 low, 2 high, back to halted; `period_count` +1.
- **Halt in high phase:** `halt_req` in the first high cycle with `half`=3 → 2 more high cycles, `out_clk` falls, `halted`=1 one cycle later. No high phase shorter than 3.
- **Reconfigure while running:** `cfg_half`=5 during a low phase with `half`=2 → `cfg_ready` drops. The current low phase finishes at 2 cycles, then high 5, low 5. `cfg_ready` returns at the rising toggle.
- **Clamp and simultaneous requests:**
  - `cfg_half`=0 → period of 2 cycles.
  - In HALTED, `run` and `step_req` together → RUNNING and continues past one period.
- **Reset mid-high:** `reset` asserted mid-high → `out_clk`=0 asynchronously. After release, `period_count`=0, `half`=`DEFAULT_HALF`, `pend_valid` cleared.
